// File: rtl/e10_mon_test_seq_if.sv
// Avalon-MM command/response bundle between the test sequencer (master)
// and the e10 packet monitor CSR space (slave).
interface e10_mon_test_seq_if;
   logic [7:0]  address;
   logic        write;
   logic        read;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        waitrequest;

   modport master (
      output address, write, read, writedata,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, write, read, writedata,
      output readdata, waitrequest
   );
endinterface

// File: rtl/e10_mon_test_seq.sv
// e10_mon_test_seq: runs one end-to-end traffic test against the e10
// packet monitor. It programs the monitor CSRs, fires the generator, polls
// status until done/timeout/abort, reads the counters and reports a verdict.
module e10_mon_test_seq #(
   parameter logic [31:0] TIMEOUT  = 32'd1_000_000,
   parameter logic [15:0] POLL_GAP = 16'd16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_start,
   input  logic                      i_abort,
   input  logic [47:0]               i_cfg_dst_mac,
   input  logic [47:0]               i_cfg_src_mac,
   input  logic [31:0]               i_cfg_pkt_num,
   e10_mon_test_seq_if.master        mm,
   output logic                      o_gen_start,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_pass,
   output logic [7:0]                o_status,
   output logic [31:0]               o_good_cnt,
   output logic [31:0]               o_bad_cnt
);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_DA0, S_WR_DA1, S_WR_SA0, S_WR_SA1, S_WR_NUM, S_WR_ARM,
      S_GEN, S_WAIT, S_RD_STAT, S_WR_STOP, S_RD_STAT_F, S_RD_GOOD, S_RD_BAD,
      S_REPORT
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_start_d;
   logic        r_write, r_read;
   logic [7:0]  r_addr;
   logic [31:0] r_wdata;
   logic        r_gen, r_busy, r_done, r_pass;
   logic [4:0]  r_stat;
   logic        r_timeout, r_aborted;
   logic [31:0] r_good, r_bad;
   logic [15:0] r_da_hi;
   logic [47:0] r_sa;
   logic [31:0] r_num;
   logic [31:0] r_tmo_cnt;
   logic [15:0] r_gap_cnt;

   logic        w_start_edge, w_active, w_xfer_done, w_abort_any, w_tmo_hit;
   logic        w_raise, w_pass;
   logic [7:0]  w_mm_addr;
   logic [31:0] w_mm_wdata;
   logic        w_mm_rd;

   function automatic state_t f_succ(input state_t s);
      case (s)
         S_WR_DA0:    f_succ = S_WR_DA1;
         S_WR_DA1:    f_succ = S_WR_SA0;
         S_WR_SA0:    f_succ = S_WR_SA1;
         S_WR_SA1:    f_succ = S_WR_NUM;
         S_WR_NUM:    f_succ = S_WR_ARM;
         S_WR_ARM:    f_succ = S_GEN;
         S_WR_STOP:   f_succ = S_RD_STAT_F;
         S_RD_STAT_F: f_succ = S_RD_GOOD;
         S_RD_GOOD:   f_succ = S_RD_BAD;
         S_RD_BAD:    f_succ = S_REPORT;
         default:     f_succ = S_IDLE;
      endcase
   endfunction

   assign w_start_edge = (r_state == S_IDLE) && i_start && !r_start_d;
   assign w_active     = r_write || r_read;
   assign w_xfer_done  = w_active && !mm.waitrequest;
   assign w_abort_any  = i_abort || r_aborted;
   assign w_tmo_hit    = (r_tmo_cnt >= TIMEOUT);
   assign w_pass       = (r_state == S_RD_BAD) && (r_stat == 5'h01) &&
                         (mm.readdata == '0) && (r_good == r_num) &&
                         !r_timeout && !w_abort_any;

   // Next-state decode; w_raise launches a strobe on the coming edge.
   // A completed transfer always leaves one strobe-free cycle before the next.
   always_comb begin
      w_state_nxt = r_state;
      w_raise     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_edge) begin
               w_state_nxt = S_WR_DA0;
               w_raise     = 1'b1;
            end
         end
         S_WR_DA0, S_WR_DA1, S_WR_SA0, S_WR_SA1, S_WR_NUM, S_WR_ARM: begin
            if (w_active) begin
               if (w_xfer_done) w_state_nxt = w_abort_any ? S_REPORT : f_succ(r_state);
            end else if (w_abort_any) begin
               w_state_nxt = S_REPORT;
            end else begin
               w_raise = 1'b1;
            end
         end
         S_GEN: begin
            w_state_nxt = w_abort_any ? S_WR_STOP : S_WAIT;
            w_raise     = w_abort_any;
         end
         S_WAIT: begin
            if (w_abort_any || w_tmo_hit) begin
               w_state_nxt = S_WR_STOP;
               w_raise     = 1'b1;
            end else if (r_gap_cnt >= POLL_GAP - 16'd1) begin
               w_state_nxt = S_RD_STAT;
               w_raise     = 1'b1;
            end
         end
         S_RD_STAT: begin
            if (w_active) begin
               if (w_xfer_done) begin
                  if (mm.readdata[0])              w_state_nxt = S_RD_GOOD;
                  else if (w_abort_any || w_tmo_hit) w_state_nxt = S_WR_STOP;
                  else                               w_state_nxt = S_WAIT;
               end
            end else begin
               w_raise = 1'b1;
            end
         end
         S_WR_STOP, S_RD_STAT_F, S_RD_GOOD, S_RD_BAD: begin
            if (w_active) begin
               if (w_xfer_done) w_state_nxt = f_succ(r_state);
            end else begin
               w_raise = 1'b1;
            end
         end
         S_REPORT: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Address/data for the transfer about to be launched (keyed on next state).
   // DA0 is only ever launched on the start edge, so it takes the live input.
   always_comb begin
      w_mm_addr  = '0;
      w_mm_wdata = '0;
      w_mm_rd    = 1'b0;
      case (w_state_nxt)
         S_WR_DA0:    begin w_mm_addr = 8'd0; w_mm_wdata = i_cfg_dst_mac[31:0]; end
         S_WR_DA1:    begin w_mm_addr = 8'd1; w_mm_wdata = {16'h0000, r_da_hi}; end
         S_WR_SA0:    begin w_mm_addr = 8'd2; w_mm_wdata = r_sa[31:0]; end
         S_WR_SA1:    begin w_mm_addr = 8'd3; w_mm_wdata = {16'h0000, r_sa[47:32]}; end
         S_WR_NUM:    begin w_mm_addr = 8'd4; w_mm_wdata = r_num; end
         S_WR_ARM:    begin w_mm_addr = 8'd5; w_mm_wdata = 32'h1; end
         S_WR_STOP:   begin w_mm_addr = 8'd5; w_mm_wdata = 32'h2; end
         S_RD_STAT,
         S_RD_STAT_F: begin w_mm_addr = 8'd6; w_mm_rd = 1'b1; end
         S_RD_GOOD:   begin w_mm_addr = 8'd7; w_mm_rd = 1'b1; end
         S_RD_BAD:    begin w_mm_addr = 8'd8; w_mm_rd = 1'b1; end
         default:     ;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Bus strobes, config latches, poll counters, captured results, verdict.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_start_d <= 1'b0;
         r_write   <= 1'b0;
         r_read    <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_gen     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_stat    <= '0;
         r_timeout <= 1'b0;
         r_aborted <= 1'b0;
         r_good    <= '0;
         r_bad     <= '0;
         r_da_hi   <= '0;
         r_sa      <= '0;
         r_num     <= '0;
         r_tmo_cnt <= '0;
         r_gap_cnt <= '0;
      end else begin
         r_start_d <= i_start;
         r_gen     <= (w_state_nxt == S_GEN);
         r_done    <= 1'b0;

         if (w_raise) begin
            r_write <= !w_mm_rd;
            r_read  <= w_mm_rd;
            r_addr  <= w_mm_addr;
            r_wdata <= w_mm_wdata;
         end else if (w_xfer_done) begin
            r_write <= 1'b0;
            r_read  <= 1'b0;
         end

         if (w_start_edge) begin
            r_da_hi   <= i_cfg_dst_mac[47:32];
            r_sa      <= i_cfg_src_mac;
            r_num     <= i_cfg_pkt_num;
            r_busy    <= 1'b1;
            r_pass    <= 1'b0;
            r_stat    <= '0;
            r_timeout <= 1'b0;
            r_aborted <= 1'b0;
            r_good    <= '0;
            r_bad     <= '0;
         end

         if (i_abort && r_state != S_IDLE && r_state != S_REPORT) r_aborted <= 1'b1;

         if (w_tmo_hit && w_state_nxt == S_WR_STOP &&
             (r_state == S_WAIT || r_state == S_RD_STAT)) r_timeout <= 1'b1;

         if (r_state == S_GEN && w_state_nxt == S_WAIT)      r_tmo_cnt <= '0;
         else if ((r_state == S_WAIT || r_state == S_RD_STAT) && r_tmo_cnt != '1)
            r_tmo_cnt <= r_tmo_cnt + 32'd1;

         if (w_state_nxt == S_WAIT && r_state != S_WAIT) r_gap_cnt <= '0;
         else if (r_state == S_WAIT)                     r_gap_cnt <= r_gap_cnt + 16'd1;

         if (w_xfer_done && r_read) begin
            case (r_state)
               S_RD_STAT, S_RD_STAT_F: r_stat <= mm.readdata[4:0];
               S_RD_GOOD:              r_good <= mm.readdata;
               S_RD_BAD:               r_bad  <= mm.readdata;
               default:                ;
            endcase
         end

         if (w_state_nxt == S_REPORT) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_pass <= w_pass;
         end
      end
   end

   assign mm.address   = r_addr;
   assign mm.write     = r_write;
   assign mm.read      = r_read;
   assign mm.writedata = r_wdata;
   assign o_gen_start  = r_gen;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_pass       = r_pass;
   assign o_status     = {r_timeout, r_aborted, 1'b0, r_stat};
   assign o_good_cnt   = r_good;
   assign o_bad_cnt    = r_bad;

endmodule

// File: tb/tb_e10_mon_test_seq.sv
// Bench for e10_mon_test_seq: a behavioural monitor slave with configurable
// stall, a table of directed tests, randomized tests, and hand sequences for
// timeout, abort and reset-during-poll.
module tb_e10_mon_test_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [47:0] cfg_da = '0, cfg_sa = '0;
   logic [31:0] cfg_num = '0;
   logic        gen_start, busy, done, pass;
   logic [7:0]  status;
   logic [31:0] good_cnt, bad_cnt;

   e10_mon_test_seq_if mm();

   e10_mon_test_seq #(.TIMEOUT(32'd200), .POLL_GAP(16'd16)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
      .i_cfg_dst_mac(cfg_da), .i_cfg_src_mac(cfg_sa), .i_cfg_pkt_num(cfg_num),
      .mm(mm),
      .o_gen_start(gen_start), .o_busy(busy), .o_done(done), .o_pass(pass),
      .o_status(status), .o_good_cnt(good_cnt), .o_bad_cnt(bad_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- monitor slave model ----------------
   int unsigned sl_stall = 1, sl_done_after = 1;
   logic [31:0] sl_stat = '0, sl_good = '0, sl_bad = '0;
   int unsigned wcnt = 0, nreads = 0;
   logic [31:0] rd_val;

   always @(posedge clk) begin
      if (mm.write || mm.read) wcnt <= wcnt + 1;
      else                     wcnt <= 0;
      if (!busy) nreads <= 0;
      else if (mm.read && !mm.waitrequest && mm.address == 8'd6) nreads <= nreads + 1;
   end

   assign mm.waitrequest = (mm.write || mm.read) && (wcnt < sl_stall);

   always_comb begin
      rd_val = '0;
      case (mm.address)
         8'd6: if (nreads + 1 >= sl_done_after) rd_val = sl_stat;
         8'd7: rd_val = sl_good;
         8'd8: rd_val = sl_bad;
         default: rd_val = '0;
      endcase
   end
   assign mm.readdata = rd_val;

   // ---------------- bus observer ----------------
   logic [39:0] wlog[$];
   int unsigned gen_cnt = 0, stab_err = 0, both_err = 0, cyc = 0, gen_cyc = 0, stop_cyc = 0;
   logic        busy_d = 1'b0, hold_pend = 1'b0;
   logic [41:0] hold_val = '0;

   always @(negedge clk) begin
      busy_d <= busy;
      cyc    <= cyc + 1;
      if (busy && !busy_d) begin
         wlog.delete();
         gen_cnt  <= 0;
         stab_err <= 0;
         both_err <= 0;
      end else begin
         if (mm.write && !mm.waitrequest) wlog.push_back({mm.address, mm.writedata});
         if (mm.write && !mm.waitrequest && mm.address == 8'd5 && mm.writedata == 32'd2)
            stop_cyc <= cyc;
         if (gen_start) begin
            gen_cnt <= gen_cnt + 1;
            gen_cyc <= cyc;
         end
         if (hold_pend && {mm.write, mm.read, mm.address, mm.writedata} !== hold_val)
            stab_err <= stab_err + 1;
         if (mm.write && mm.read) both_err <= both_err + 1;
      end
      hold_pend <= (mm.write || mm.read) && mm.waitrequest;
      hold_val  <= {mm.write, mm.read, mm.address, mm.writedata};
   end

   // ---------------- checking ----------------
   int unsigned n_total = 0, n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [47:0] da, sa;
      logic [31:0] num, good, bad;
      logic [4:0]  stat;
      int unsigned stall, done_after;
      logic        exp_pass;
      logic [7:0]  exp_status;
   } vec_t;

   // Reference: the CSR programming sequence the monitor must see.
   function automatic logic [39:0] exp_wr(input vec_t v, input int unsigned i);
      case (i)
         0: return {8'd0, v.da[31:0]};
         1: return {8'd1, 16'h0, v.da[47:32]};
         2: return {8'd2, v.sa[31:0]};
         3: return {8'd3, 16'h0, v.sa[47:32]};
         4: return {8'd4, v.num};
         default: return {8'd5, 32'd1};
      endcase
   endfunction

   task automatic wait_done(input string tag);
      int unsigned n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ":done_seen"}, done, 1'b1);
   endtask

   task automatic setup(input vec_t v);
      sl_stall = v.stall; sl_done_after = v.done_after;
      sl_stat = {27'h0, v.stat}; sl_good = v.good; sl_bad = v.bad;
      cfg_da = v.da; cfg_sa = v.sa; cfg_num = v.num;
   endtask

   task automatic run_test(input vec_t v, input string tag);
      setup(v);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      chk({tag, ":first_wr"}, {busy, mm.write, mm.address}, {1'b1, 1'b1, 8'd0});
      cfg_da = ~v.da; cfg_sa = ~v.sa; cfg_num = ~v.num;
      wait_done(tag);
      chk({tag, ":pass"}, pass, v.exp_pass);
      chk({tag, ":status"}, status, v.exp_status);
      chk({tag, ":good"}, good_cnt, v.good);
      chk({tag, ":bad"}, bad_cnt, v.bad);
      chk({tag, ":busy_at_done"}, busy, 1'b0);
      chk({tag, ":nwrites"}, wlog.size(), 6);
      for (int unsigned i = 0; i < 6; i++)
         if (i < wlog.size()) chk({tag, $sformatf(":wr%0d", i)}, wlog[i], exp_wr(v, i));
      chk({tag, ":gen_pulses"}, gen_cnt, 1);
      chk({tag, ":stable"}, stab_err, 0);
      chk({tag, ":rd_wr_excl"}, both_err, 0);
      repeat (3) @(negedge clk);
      chk({tag, ":no_retrigger"}, {busy, done}, 2'b00);
      start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   vec_t tbl[6];
   vec_t v;
   logic [63:0] r64;
   int unsigned d;

   initial begin
      tbl[0] = '{48'h0011_2233_4455, 48'h6677_8899_AABB, 32'd100, 32'd100, 32'd0, 5'h01, 1, 3, 1'b1, 8'h01};
      tbl[1] = '{48'h0011_2233_4455, 48'h6677_8899_AABB, 32'd100, 32'd98,  32'd2, 5'h11, 1, 2, 1'b0, 8'h11};
      tbl[2] = '{48'h0011_2233_4455, 48'h6677_8899_AABB, 32'd100, 32'd100, 32'd0, 5'h01, 5, 3, 1'b1, 8'h01};
      tbl[3] = '{48'hFFFF_0000_FFFF, 48'h0000_FFFF_0000, 32'd7,   32'd6,   32'd0, 5'h01, 2, 1, 1'b0, 8'h01};
      tbl[4] = '{48'h1234_5678_9ABC, 48'hDEF0_1234_5678, 32'd5,   32'd5,   32'd0, 5'h03, 3, 2, 1'b0, 8'h03};
      tbl[5] = '{48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'h01, 1, 1, 1'b1, 8'h01};

      repeat (3) @(negedge clk);
      chk("reset_outputs", {mm.write, mm.read, mm.address, mm.writedata, gen_start, busy, done,
                            pass, status, good_cnt, bad_cnt}, '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int unsigned i = 0; i < 6; i++) run_test(tbl[i], $sformatf("tbl%0d", i));

      for (int unsigned i = 0; i < 16; i++) begin
         r64 = {$urandom(), $urandom()}; v.da = r64[47:0];
         r64 = {$urandom(), $urandom()}; v.sa = r64[47:0];
         v.num = $urandom_range(1, 1000);
         if ($urandom_range(0, 1) == 1) begin
            v.good = v.num; v.bad = 0; v.stat = 5'h01;
         end else begin
            v.good = $urandom_range(0, 1000); v.bad = $urandom_range(0, 3);
            v.stat = {4'($urandom_range(0, 15)), 1'b1};
         end
         v.stall = $urandom_range(1, 5);
         v.done_after = $urandom_range(1, 4);
         v.exp_pass = (v.stat == 5'h01) && (v.bad == 0) && (v.good == v.num);
         v.exp_status = {3'b000, v.stat};
         run_test(v, $sformatf("rnd%0d", i));
      end

      // Timeout: done never reported.
      v = tbl[0]; v.done_after = 32'hFFFF_FFFF; v.good = 32'd5; v.bad = 32'd0;
      setup(v);
      @(negedge clk); start = 1'b1;
      wait_done("tmo");
      start = 1'b0;
      chk("tmo:status", status, 8'h80);
      chk("tmo:pass", pass, 1'b0);
      chk("tmo:good", good_cnt, 32'd5);
      chk("tmo:nwrites", wlog.size(), 7);
      if (wlog.size() == 7) chk("tmo:stop_wr", wlog[6], {8'd5, 32'd2});
      d = stop_cyc - gen_cyc;
      n_total++;
      if (!(d >= 198 && d <= 215)) begin
         n_bad++;
         $display("FAIL tmo:stop_delay got %0d expected 198..215", d);
      end
      repeat (3) @(negedge clk);

      // Abort while SA0 write is stalled.
      setup(tbl[0]);
      @(negedge clk); start = 1'b1;
      d = 0;
      while (!(mm.write && mm.address == 8'd2 && mm.waitrequest) && d < 200) begin
         @(negedge clk);
         d++;
      end
      chk("abort:reached_sa0", d < 200, 1'b1);
      abort = 1'b1;
      wait_done("abort");
      chk("abort:status", status, 8'h40);
      chk("abort:pass", pass, 1'b0);
      chk("abort:counts", {good_cnt, bad_cnt}, 64'h0);
      chk("abort:nwrites", wlog.size(), 3);
      if (wlog.size() == 3) chk("abort:last_wr", wlog[2], exp_wr(tbl[0], 2));
      chk("abort:gen_pulses", gen_cnt, 0);
      abort = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);

      // Reset during the poll phase.
      v = tbl[0]; v.done_after = 32'hFFFF_FFFF;
      setup(v);
      @(negedge clk); start = 1'b1;
      d = 0;
      while (gen_cnt == 0 && d < 300) begin
         @(negedge clk);
         d++;
      end
      chk("rst:gen_seen", gen_cnt, 1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst:outputs_zero", {mm.write, mm.read, mm.address, mm.writedata, gen_start, busy, done,
                               pass, status, good_cnt, bad_cnt}, '0);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      run_test(tbl[0], "after_rst");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/e10_mon_test_seq.md
# e10_mon_test_seq

Sequencer that runs one end-to-end traffic test against the e10 Avalon-ST packet monitor. Acting as an Avalon-MM master on the monitor's 8-bit CSR space, it programs the expected MAC addresses and packet count, arms the monitor, and fires the packet generator. It then polls monitor status until done, timeout or abort, reads the good/bad counters and reports a single pass/fail verdict. It sits between the AFU host CSR block (which supplies configuration and `start`) and the monitor.

## Interface
- `TIMEOUT`, 32'd1_000_000: max cycles in the poll phase before forced stop.
- `POLL_GAP`, 16'd16: idle cycles before each status read; must be ≥4.
- `clk` in 1: single clock domain.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: level; a rising edge in IDLE launches a test.
- `abort` in 1: level; requests early termination.
- `cfg_dst_mac` in 48: expected destination MAC.
- `cfg_src_mac` in 48: expected source MAC.
- `cfg_pkt_num` in 32: expected packet count; sampled at start.
- `mm_address` out 8: monitor CSR address.
- `mm_write`, `mm_read` out 1: command strobes. Never both high.
- `mm_writedata` out 32: write data.
- `mm_readdata` in 32: read data.
- `mm_waitrequest` in 1: slave stall.
- `gen_start` out 1: one-cycle pulse to the packet generator.
- `busy` out 1: high from the start edge until the `done` pulse.
- `done` out 1: one-cycle pulse when the verdict is valid.
- `pass` out 1: verdict; held until the next start.
- `status` out 8: `{timeout, aborted, 1'b0, mon_error, len_err, sa_err, da_err, mon_done}`; held.
- `good_cnt`, `bad_cnt` out 32: counter values read back; held.

## Operation
- Monitor CSR map:
  - 0 DA[31:0], 1 DA[47:32], 2 SA[31:0], 3 SA[47:32], 4 PKT_NUMB.
  - 5 CTRL: bit0 start, bit1 stop, bit2 continuous.
  - 6 STAT: bit0 done, bit1 da_err, bit2 sa_err, bit3 len_err, bit4 mon_error.
  - 7 GOOD, 8 BAD.
- All config inputs are latched on the start edge. Later changes have no effect until the next test.
- FSM state sequence:
  - IDLE
  - WR_DA0 → WR_DA1 → WR_SA0 → WR_SA1 → WR_NUM
  - WR_ARM (CTRL=0x1) → GEN (`gen_start` pulse, 1 cycle)
  - WAIT (POLL_GAP cycles) → RD_STAT
  - RD_STAT: if done bit is 0, return to WAIT; if done bit is 1, go to RD_GOOD.
  - RD_GOOD → RD_BAD → REPORT → IDLE.
- MAC high-word writes place the MAC's upper 16 bits in writedata[15:0]; writedata[31:16] is 0.
- Timeout: a 32-bit counter is cleared on entry to WAIT from GEN and increments in WAIT and RD_STAT.
  - When the count reaches TIMEOUT, the FSM goes to WR_STOP (CTRL=0x2), then RD_STAT_F → RD_GOOD → RD_BAD → REPORT.
  - `timeout` is set.
- Abort: abort high in any state other than IDLE/REPORT sets a sticky `aborted` flag.
  - An in-flight MM transfer always completes first.
  - If abort occurs before WR_ARM completes, go directly to REPORT; counters read as 0.
  - Otherwise take the WR_STOP path as for timeout.
- Verdict: `pass` = 1 only if all of the following hold:
  - stat done = 1 and stat[4:1] = 0
  - bad = 0 and good = latched `cfg_pkt_num`
  - no timeout and no abort
- `status[4:0]` is the last STAT word read.
- Start edges while busy are ignored. `start` held high across REPORT does not retrigger; a new rising edge is required.

## Timing
- Reset values: `mm_*` = 0, `gen_start` = 0, `busy` = 0, `done` = 0, `pass` = 0, `status` = 0, counts = 0, state = IDLE.
- All outputs are registered.
- MM handshake:
  - Address, data and strobe are asserted together and held stable while waitrequest = 1.
  - A transfer completes in the cycle where strobe = 1 and waitrequest = 0.
  - Readdata is sampled in that cycle. The strobe drops in the next cycle.
  - Against the monitor, which asserts waitrequest for exactly the first cycle, each transfer takes 2 cycles plus 1 dead cycle. Back-to-back strobes are forbidden, because the slave only stalls on a strobe rising edge.
- `start` edge to first `mm_write`: 1 cycle.
- WR_ARM completion to `gen_start`: 1 cycle.
- POLL_GAP guarantees a stale done = 1 is not read before the monitor's init pulse clears it.
- `done` pulses 1 cycle after RD_BAD completes. `busy` falls in the same cycle.
- Reset mid-test returns to IDLE immediately; any in-flight strobe drops asynchronously.

## Test plan
- Nominal, with a monitor model:
  - Stimulus: DA=0x0011_2233_4455, SA=0x6677_8899_AABB, pkt_num=100; good=100, bad=0, STAT=0x01.
  - Required: write sequence addr 0..5 with data 0x22334455, 0x0011, 0x8899AABB, 0x6677, 100, 0x1; one `gen_start`; `pass`=1; `status`=0x01.
- CRC failures:
  - Stimulus: good=98, bad=2, STAT=0x11.
  - Required: `pass`=0, `status`=0x11, `bad_cnt`=2.
- Timeout:
  - Stimulus: TIMEOUT=200, STAT done never sets.
  - Required: CTRL=0x2 written about 200 cycles after GEN; `status[7]`=1; `pass`=0.
- Abort:
  - Stimulus: abort during WR_SA0 while waitrequest is high.
  - Required: WR_SA0 completes; REPORT follows with no ARM write and no `gen_start`; `status`=0x40.
- Waitrequest stretch:
  - Stimulus: slave holds waitrequest for 5 cycles per transfer.
  - Required: address/data stay stable throughout; the sequence is unchanged.
- Reset during poll:
  - Stimulus: assert reset in WAIT.
  - Required: all outputs 0 the same cycle; a new start runs cleanly.
